// File: rtl/traffic_generator_pkg.sv
// Shared NoC definitions for the traffic generator: packet layout, FSM
// encodings, LFSR taps and a small coordinate helper.
package traffic_generator_pkg;

   // Packet field layout (LSB offset and width of each field)
   localparam int PKT_DST_LSB = 26;
   localparam int PKT_DST_W   = 6;
   localparam int PKT_TS_LSB  = 16;
   localparam int PKT_TS_W    = 10;
   localparam int PKT_ID_LSB  = 6;
   localparam int PKT_ID_W    = 10;
   localparam int PKT_SRC_LSB = 0;
   localparam int PKT_SRC_W   = 6;

   localparam int COORD_W = 3;
   localparam int NODE_W  = 2 * COORD_W;
   localparam int LFSR_W  = 16;

   // Fibonacci taps 16,14,13,11 -> bit indices 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_GAP  = 3'd1;
   localparam logic [2:0] ST_REQ  = 3'd2;
   localparam logic [2:0] ST_ACK  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Folds a raw 3-bit coordinate into the mesh range 0..d-1.
   function automatic logic [COORD_W-1:0] coord_mod(input logic [COORD_W-1:0] v,
                                                    input int unsigned d);
      return COORD_W'(32'(v) % d);
   endfunction

endpackage

// File: rtl/traffic_generator_dest_lfsr.sv
// Pseudo-random destination source: 16-bit Fibonacci LFSR whose low bits are
// mapped onto mesh coordinates, never pointing back at the local router.
module dest_lfsr
   import traffic_generator_pkg::*;
#(
   parameter logic [5:0]  routerID  = 6'b000_000,
   parameter int          dim       = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       advance,
   output logic [5:0] destID
);

   logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic               feedback;
   logic [COORD_W-1:0] dst_x, dst_y, dst_x_bump;

   // Next LFSR value: shift in the XOR of the tapped bits on each advance
   always_comb begin
      feedback = ^(lfsr_q & LFSR_TAPS);
      lfsr_d   = advance ? {lfsr_q[LFSR_W-2:0], feedback} : lfsr_q;
   end

   // LFSR register, reseeded on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   // Map to {x,y}; a hit on our own node is nudged one step along x
   always_comb begin
      dst_x      = coord_mod(lfsr_q[2:0], dim);
      dst_y      = coord_mod(lfsr_q[5:3], dim);
      dst_x_bump = coord_mod(dst_x + 3'd1, dim);
      if ({dst_x, dst_y} == routerID) destID = {dst_x_bump, dst_y};
      else                            destID = {dst_x, dst_y};
   end

endmodule

// File: rtl/traffic_generator.sv
// NoC traffic generator: injects NUM_PACKETS packets into the router local
// port, spaced INJ_PERIOD cycles apart, with a req/grant handshake.
//
//   state | meaning
//   IDLE  | waiting for Enable with packets still to send
//   GAP   | counting down the inter-packet gap, then waiting for buffer space
//   REQ   | request held with a stable packet until the router grants
//   ACK   | waiting for the grant to drop before the next packet
//   DONE  | all packets accepted; parked until reset
module traffic_generator
   import traffic_generator_pkg::*;
#(
   parameter logic [5:0]  routerID    = 6'b000_000,
   parameter int          dataWidth   = 32,
   parameter int          dim         = 4,
   parameter int          INJ_PERIOD  = 8,
   parameter int          NUM_PACKETS = 100,
   parameter int          DEST_MODE   = 1,
   parameter logic [5:0]  DEST_ID     = 6'b011_011,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Enable,
   input  logic                 DnStrFull,
   input  logic                 GntDnStr,
   output logic [dataWidth-1:0] PacketOut,
   output logic                 ReqDnStr,
   output logic [15:0]          SentCount,
   output logic                 Done
);

   localparam int               GAP_W    = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(INJ_PERIOD - 1);
   localparam logic [15:0]      NUM_PKT  = 16'(NUM_PACKETS);

   logic [2:0]           state_q, state_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [dataWidth-1:0] pkt_q, pkt_d, pkt_new;
   logic                 req_q, req_d;
   logic [15:0]          sent_q, sent_d;
   logic [PKT_ID_W-1:0]  id_q, id_d;
   logic [31:0]          cycle_q;
   logic                 cycle_unused;
   logic                 advance;
   logic [NODE_W-1:0]    lfsr_dest, dest_sel;

   dest_lfsr #(
      .routerID  (routerID),
      .dim       (dim),
      .LFSR_SEED (LFSR_SEED)
   ) u_dest_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .destID  (lfsr_dest)
   );

   assign dest_sel = (DEST_MODE == 0) ? DEST_ID : lfsr_dest;

   // Only the low timestamp bits travel in the packet
   assign cycle_unused = ^cycle_q[31:PKT_TS_W];

   // Free-running cycle counter used to timestamp packets
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cycle_q <= '0;
      else        cycle_q <= cycle_q + 32'd1;
   end

   // Assemble the packet that would be latched this cycle
   always_comb begin
      pkt_new                               = '0;
      pkt_new[PKT_DST_LSB +: PKT_DST_W]     = dest_sel;
      pkt_new[PKT_TS_LSB  +: PKT_TS_W]      = cycle_q[PKT_TS_W-1:0];
      pkt_new[PKT_ID_LSB  +: PKT_ID_W]      = id_q;
      pkt_new[PKT_SRC_LSB +: PKT_SRC_W]     = routerID;
   end

   // Injection FSM next-state logic
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pkt_d   = pkt_q;
      req_d   = req_q;
      sent_d  = sent_q;
      id_d    = id_q;
      advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Enable && (sent_q < NUM_PKT)) begin
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else if (!DnStrFull) begin
               pkt_d   = pkt_new;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Once raised, the request stays up until granted
            if (GntDnStr) begin
               req_d   = 1'b0;
               id_d    = id_q + 10'd1;
               sent_d  = sent_q + 16'd1;
               advance = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!GntDnStr) begin
               if (sent_q == NUM_PKT) begin
                  state_d = ST_DONE;
               end else if (Enable) begin
                  gap_d   = GAP_LOAD;
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            req_d = 1'b0;
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight request immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         pkt_q   <= '0;
         req_q   <= 1'b0;
         sent_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         pkt_q   <= pkt_d;
         req_q   <= req_d;
         sent_q  <= sent_d;
         id_q    <= id_d;
      end
   end

   assign PacketOut = pkt_q;
   assign ReqDnStr  = req_q;
   assign SentCount = sent_q;
   assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_traffic_generator.sv
// Bench for traffic_generator: a random-destination instance driven through
// timing, back-pressure, reset and PacketID wrap, plus a small fixed-
// destination instance. Expected packets are queued as stimulus is issued
// and compared by a separate monitor when a request rises.
module tb_traffic_generator;

   localparam logic [5:0]  M_ROUTER = 6'b001_010;
   localparam int          M_NUM    = 1100;
   localparam logic [15:0] SEED     = 16'hACE1;

   logic clk   = 1'b0;
   logic rst_b = 1'b1;

   logic        m_en = 1'b0, m_full = 1'b0, m_gnt = 1'b0;
   logic [31:0] m_pkt;
   logic        m_req;
   logic [15:0] m_sent;
   logic        m_done;

   logic        f_en = 1'b0, f_full = 1'b0, f_gnt = 1'b0;
   logic [31:0] f_pkt;
   logic        f_req;
   logic [15:0] f_sent;
   logic        f_done;

   always #5 clk = ~clk;

   traffic_generator #(
      .routerID (M_ROUTER), .dataWidth (32), .dim (4), .INJ_PERIOD (8),
      .NUM_PACKETS (M_NUM), .DEST_MODE (1), .DEST_ID (6'b011_011), .LFSR_SEED (SEED)
   ) u_main (
      .clk (clk), .reset (rst_b), .Enable (m_en), .DnStrFull (m_full), .GntDnStr (m_gnt),
      .PacketOut (m_pkt), .ReqDnStr (m_req), .SentCount (m_sent), .Done (m_done)
   );

   traffic_generator #(
      .routerID (6'b000_000), .dataWidth (32), .dim (4), .INJ_PERIOD (2),
      .NUM_PACKETS (3), .DEST_MODE (0), .DEST_ID (6'b011_011), .LFSR_SEED (SEED)
   ) u_fixed (
      .clk (clk), .reset (rst_b), .Enable (f_en), .DnStrFull (f_full), .GntDnStr (f_gnt),
      .PacketOut (f_pkt), .ReqDnStr (f_req), .SentCount (f_sent), .Done (f_done)
   );

   typedef struct packed {
      logic [5:0] dest;
      logic [9:0] id;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned ref_cyc = 0;
   logic [15:0] mdl_lfsr;
   int          mdl_id;
   int          mdl_sent;
   logic        prev_req = 1'b0;

   // Reference cycle counter: cleared by reset, +1 per clock
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) ref_cyc <= 0;
      else        ref_cyc <= ref_cyc + 1;
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic fb;
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      return {l[14:0], fb};
   endfunction

   function automatic logic [5:0] model_dest(input logic [15:0] l);
      int x, y;
      x = int'(l[2:0]) % 4;
      y = int'(l[5:3]) % 4;
      if ({x[2:0], y[2:0]} == M_ROUTER) x = (x + 1) % 4;
      return {x[2:0], y[2:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected();
      sb.push_back({model_dest(mdl_lfsr), 10'(mdl_id)});
   endtask

   task automatic model_reset();
      mdl_lfsr = SEED;
      mdl_id   = 0;
      mdl_sent = 0;
      sb.delete();
      push_expected();
   endtask

   task automatic wait_req(input int budget, output int n);
      n = 0;
      while (!m_req && n < budget) begin
         tick();
         n++;
      end
      if (!m_req) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_timeout: no request after %0d cycles, required one within %0d", n, budget);
      end
   endtask

   // Responder: grant one cycle after the request is seen, drop it the next
   task automatic do_grant();
      tick();
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      mdl_sent++;
      mdl_id   = (mdl_id + 1) % 1024;
      mdl_lfsr = lfsr_next(mdl_lfsr);
      check("req_drop_on_gnt", 32'(m_req), 0);
      check("sent_count", 32'(m_sent), mdl_sent);
      check("done_early", 32'(m_done), 0);
      if (mdl_sent < M_NUM) push_expected();
   endtask

   // Monitor: compare every newly raised request against the scoreboard
   initial begin
      exp_t        e;
      logic [31:0] ts;
      logic [31:0] exp_pkt;
      forever begin
         @(negedge clk);
         if (m_req && !prev_req) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_req: got request with packet 0x%0h, required none", m_pkt);
            end else begin
               e       = sb.pop_front();
               ts      = ref_cyc - 1;
               exp_pkt = {e.dest, ts[9:0], e.id, M_ROUTER};
               check("packet", m_pkt, exp_pkt);
               check("dest_not_self", 32'(m_pkt[31:26] == M_ROUTER), 0);
               check("dest_range", 32'((m_pkt[31:29] < 3'd4) && (m_pkt[28:26] < 3'd4)), 1);
            end
         end
         prev_req = m_req;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int viol;
      logic [31:0] snap;

      model_reset();
      #1 rst_b = 1'b0;
      repeat (3) tick();
      check("rst_req", 32'(m_req), 0);
      check("rst_sent", 32'(m_sent), 0);
      check("rst_done", 32'(m_done), 0);
      check("rst_pkt", m_pkt, 0);
      check("rst_fix_req", 32'(f_req), 0);
      check("rst_fix_done", 32'(f_done), 0);
      rst_b = 1'b1;
      repeat (5) tick();
      check("idle_no_enable", 32'(m_req), 0);

      // Fixed-destination instance: three packets then Done
      f_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!f_req && n < 50) begin
            tick();
            n++;
         end
         check("fix_req_seen", 32'(f_req), 1);
         check("fix_dest", 32'(f_pkt[31:26]), 32'h1B);
         check("fix_id", 32'(f_pkt[15:6]), k);
         check("fix_src", 32'(f_pkt[5:0]), 0);
         check("fix_done_pre", 32'(f_done), 0);
         tick();
         f_gnt = 1'b1;
         tick();
         f_gnt = 1'b0;
      end
      tick();
      check("fix_done", 32'(f_done), 1);
      check("fix_sent", 32'(f_sent), 3);
      viol = 0;
      repeat (20) begin
         tick();
         if (f_req) viol++;
      end
      check("fix_no_more_req", viol, 0);
      check("fix_done_held", 32'(f_done), 1);
      f_en = 1'b0;

      // Main instance: first request 8 cycles after leaving IDLE (n counts that edge too)
      m_en = 1'b1;
      wait_req(40, n);
      check("first_req_latency", n, 9);
      for (int k = 0; k < 3; k++) begin
         do_grant();
         wait_req(40, n);
         check("req_interval", n + 2, 11);
      end

      // Reset while a request is up
      #3 rst_b = 1'b0;
      #1;
      check("rst_drop_req", 32'(m_req), 0);
      check("rst_mid_sent", 32'(m_sent), 0);
      model_reset();
      tick();
      rst_b = 1'b1;
      wait_req(40, n);
      check("latency_after_reset", n, 9);
      check("id_after_reset", 32'(m_pkt[15:6]), 0);

      // Buffer full when the gap expires: no request until it clears
      do_grant();
      m_full = 1'b1;
      viol   = 0;
      repeat (20) begin
         tick();
         if (m_req) viol++;
      end
      check("full_blocks_req", viol, 0);
      m_full = 1'b0;
      wait_req(5, n);
      check("req_after_full", n, 1);

      // Buffer full during REQ: request and packet held
      m_full = 1'b1;
      snap   = m_pkt;
      viol   = 0;
      repeat (5) begin
         tick();
         if (!m_req || m_pkt !== snap) viol++;
      end
      check("hold_under_full", viol, 0);
      do_grant();
      m_full = 1'b0;
      wait_req(40, n);
      check("req_interval", n + 2, 11);

      // Enable dropped during REQ: request still held, then idle
      m_en = 1'b0;
      viol = 0;
      repeat (3) begin
         tick();
         if (!m_req) viol++;
      end
      check("hold_enable_low", viol, 0);
      do_grant();
      viol = 0;
      repeat (15) begin
         tick();
         if (m_req) viol++;
      end
      check("idle_after_disable", viol, 0);
      m_en = 1'b1;
      wait_req(40, n);
      check("latency_reenable", n, 9);

      // Remaining packets, through the PacketID wrap
      while (mdl_sent < M_NUM) begin
         do_grant();
         if (mdl_sent < M_NUM) begin
            wait_req(40, n);
            check("req_interval", n + 2, 11);
            if (mdl_sent == 1024) check("id_wrap", 32'(m_pkt[15:6]), 0);
         end
      end
      tick();
      check("final_done", 32'(m_done), 1);
      check("final_sent", 32'(m_sent), M_NUM);
      check("final_req", 32'(m_req), 0);
      viol = 0;
      repeat (30) begin
         tick();
         if (m_req) viol++;
      end
      check("no_req_after_done", viol, 0);
      check("sb_drained", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
